// File: rtl/line_option_engine.sv
// Line option engine: accepts one row/column job, flags each streamed option keep/drop
// against the board, and commits cells forced by all survivors. Optional macro: LINE_ERR_CHECK_EN.
module line_option_engine #(
  parameter int ROWS  = 3,
  parameter int COLS  = 3,
  parameter int CNT_W = 7,
  parameter int LMAX  = (ROWS > COLS) ? ROWS : COLS,
  parameter int IDX_W = $clog2(ROWS + COLS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   board_clr,
  input  logic                   line_valid,
  output logic                   line_ready,
  input  logic [IDX_W-1:0]       line_idx,
  input  logic [CNT_W-1:0]       line_cnt,
  input  logic                   opt_valid,
  output logic                   opt_ready,
  input  logic [LMAX-1:0]        opt_data,
  output logic                   opt_keep_valid,
  output logic                   opt_keep,
  output logic                   done,
  output logic [CNT_W-1:0]       new_cnt,
  output logic                   changed,
  output logic [ROWS*COLS-1:0]   known,
  output logic [ROWS*COLS-1:0]   assigned,
  output logic                   err
);

  localparam int NCELL = ROWS * COLS;
  localparam int NLINE = ROWS + COLS;
  localparam logic [IDX_W:0] ROWS_L  = ROWS[IDX_W:0];
  localparam logic [IDX_W:0] NLINE_L = NLINE[IDX_W:0];

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_COMMIT, S_DONE} state_t;

  function automatic logic [LMAX-1:0] gather(input logic [NCELL-1:0] b, input logic row,
                                             input logic [IDX_W:0] sel);
    logic [LMAX-1:0] g;
    g = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (row && int'(sel) == r) g[c] = b[r*COLS+c];
        else if (!row && int'(sel) == c) g[r] = b[r*COLS+c];
      end
    end
    return g;
  endfunction

  function automatic logic [LMAX-1:0] len_mask(input logic row);
    logic [LMAX-1:0] m;
    for (int k = 0; k < LMAX; k++) m[k] = row ? (k < COLS) : (k < ROWS);
    return m;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_t             r_state;
  logic               r_line_ready, r_opt_ready, r_keep_vld_p1, r_keep_p1;
  logic               r_done, r_changed;
  logic [CNT_W-1:0]   r_new_cnt, r_rem, r_surv;
  logic [NCELL-1:0]   r_known, r_assigned;
  logic               r_is_row;
  logic [IDX_W:0]     r_sel;
  logic [LMAX-1:0]    r_lk, r_la, r_vmask, r_acc_and, r_acc_or;

  logic [IDX_W:0]     w_idx_x, w_in_sel;
  logic               w_in_is_row, w_in_ok, w_contra, w_any_surv, w_changed;
  logic [LMAX-1:0]    w_newk;
  logic [NCELL-1:0]   w_known_nx, w_assigned_nx;

  assign w_idx_x     = {1'b0, line_idx};
  assign w_in_is_row = w_idx_x < ROWS_L;
  assign w_in_ok     = w_idx_x < NLINE_L;
  assign w_in_sel    = w_in_is_row ? w_idx_x : w_idx_x - ROWS_L;

  // Snapshot bits outside the line are zero in r_lk, so only valid cells can contradict.
  assign w_contra = |((opt_data ^ r_la) & r_lk);

  // A cell is forced when every survivor agrees: all ones (AND) or all zeros (~OR).
  assign w_any_surv = (r_surv != '0);
  assign w_newk     = r_vmask & ~r_lk & (r_acc_and | ~r_acc_or) & {LMAX{w_any_surv}};
  assign w_changed  = |w_newk;

  always_comb begin
    w_known_nx    = r_known;
    w_assigned_nx = r_assigned;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (r_is_row && int'(r_sel) == r && w_newk[c]) begin
          w_known_nx[r*COLS+c]    = 1'b1;
          w_assigned_nx[r*COLS+c] = r_acc_and[c];
        end else if (!r_is_row && int'(r_sel) == c && w_newk[r]) begin
          w_known_nx[r*COLS+c]    = 1'b1;
          w_assigned_nx[r*COLS+c] = r_acc_and[r];
        end
      end
    end
  end

`ifdef LINE_ERR_CHECK_EN
  logic r_err;
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_line_ready  <= 1'b1;
      r_opt_ready   <= 1'b0;
      r_keep_vld_p1 <= 1'b0;
      r_keep_p1     <= 1'b0;
      r_done        <= 1'b0;
      r_changed     <= 1'b0;
      r_new_cnt     <= '0;
      r_rem         <= '0;
      r_surv        <= '0;
      r_known       <= '0;
      r_assigned    <= '0;
      r_is_row      <= 1'b0;
      r_sel         <= '0;
      r_lk          <= '0;
      r_la          <= '0;
      r_vmask       <= '0;
      r_acc_and     <= '1;
      r_acc_or      <= '0;
`ifdef LINE_ERR_CHECK_EN
      r_err         <= 1'b0;
`endif
    end else begin
      r_keep_vld_p1 <= 1'b0;
      r_done        <= 1'b0;
`ifdef LINE_ERR_CHECK_EN
      r_err         <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (board_clr) begin
            r_known    <= '0;
            r_assigned <= '0;
          end else if (line_valid) begin
            r_is_row     <= w_in_is_row;
            r_sel        <= w_in_sel;
            r_lk         <= gather(r_known, w_in_is_row, w_in_sel);
            r_la         <= gather(r_assigned, w_in_is_row, w_in_sel);
            r_vmask      <= len_mask(w_in_is_row);
            r_rem        <= line_cnt;
            r_surv       <= '0;
            r_acc_and    <= '1;
            r_acc_or     <= '0;
            r_line_ready <= 1'b0;
            if (w_in_ok && line_cnt != '0) begin
              r_state     <= S_SCAN;
              r_opt_ready <= 1'b1;
            end else begin
              r_state   <= S_DONE;
              r_done    <= 1'b1;
              r_new_cnt <= '0;
              r_changed <= 1'b0;
            end
          end
        end
        // SCAN -> p1: keep strobe one cycle after each accepted option
        S_SCAN: begin
          if (opt_valid) begin
            r_keep_vld_p1 <= 1'b1;
            r_keep_p1     <= ~w_contra;
            if (!w_contra) begin
              r_surv    <= sat_inc(r_surv);
              r_acc_and <= r_acc_and & opt_data;
              r_acc_or  <= r_acc_or | opt_data;
            end
            r_rem <= r_rem - CNT_W'(1);
            if (r_rem == CNT_W'(1)) begin
              r_state     <= S_COMMIT;
              r_opt_ready <= 1'b0;
            end
          end
        end
        // COMMIT -> DONE: board write and result registers land together
        S_COMMIT: begin
          r_known    <= w_known_nx;
          r_assigned <= w_assigned_nx;
          r_changed  <= w_changed;
          r_new_cnt  <= r_surv;
          r_done     <= 1'b1;
`ifdef LINE_ERR_CHECK_EN
          r_err      <= ~w_any_surv;
`endif
          r_state    <= S_DONE;
        end
        S_DONE: begin
          r_state      <= S_IDLE;
          r_line_ready <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign line_ready     = r_line_ready;
  assign opt_ready      = r_opt_ready;
  assign opt_keep_valid = r_keep_vld_p1;
  assign opt_keep       = r_keep_p1;
  assign done           = r_done;
  assign new_cnt        = r_new_cnt;
  assign changed        = r_changed;
  assign known          = r_known;
  assign assigned       = r_assigned;

endmodule

// File: tb/tb_line_option_engine.sv
// Scoreboard bench for line_option_engine (3x3): a board-level reference model predicts
// keep strobes and done results; a negedge monitor pops and compares them.
module tb_line_option_engine;
  localparam int ROWS = 3, COLS = 3, CNT_W = 7, LMAX = 3, IDX_W = 3, NCELL = 9;

  logic clk = 1'b0, rst = 1'b1, board_clr = 1'b0, line_valid = 1'b0, opt_valid = 1'b0;
  logic [IDX_W-1:0] line_idx = '0;
  logic [CNT_W-1:0] line_cnt = '0;
  logic [LMAX-1:0]  opt_data = '0;
  logic line_ready, opt_ready, opt_keep_valid, opt_keep, done, changed, err;
  logic [CNT_W-1:0] new_cnt;
  logic [NCELL-1:0] known, assigned;

  line_option_engine #(.ROWS(ROWS), .COLS(COLS), .CNT_W(CNT_W), .LMAX(LMAX), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .board_clr(board_clr), .line_valid(line_valid),
    .line_ready(line_ready), .line_idx(line_idx), .line_cnt(line_cnt),
    .opt_valid(opt_valid), .opt_ready(opt_ready), .opt_data(opt_data),
    .opt_keep_valid(opt_keep_valid), .opt_keep(opt_keep), .done(done),
    .new_cnt(new_cnt), .changed(changed), .known(known), .assigned(assigned), .err(err));

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { bit k; int cyc; } keep_t;
  typedef struct { int cnt; bit chg; bit e; logic [NCELL-1:0] kn; logic [NCELL-1:0] as; int cyc; } done_t;
  keep_t keep_q[$];
  done_t done_q[$];
  logic [LMAX-1:0] job_opts[$];
  bit job_keeps[$];
  bit mk[ROWS][COLS], ma[ROWS][COLS], sol[ROWS][COLS];
  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: an option survives if it agrees with every known cell of the line;
  // an unknown cell becomes known when all survivors agree on its value.
  task automatic model_job(input int idx, input int cnt, output done_t d);
    bit isrow, ok, all1, all0;
    int n, line, eff, r, c;
    logic [LMAX-1:0] surv[$];
    job_keeps.delete();
    eff   = (idx < ROWS + COLS) ? cnt : 0;
    isrow = idx < ROWS;
    n     = isrow ? COLS : ROWS;
    line  = isrow ? idx : idx - ROWS;
    for (int i = 0; i < eff; i++) begin
      ok = 1;
      for (int k = 0; k < n; k++) begin
        r = isrow ? line : k;
        c = isrow ? k : line;
        if (mk[r][c] && job_opts[i][k] != ma[r][c]) ok = 0;
      end
      job_keeps.push_back(ok);
      if (ok) surv.push_back(job_opts[i]);
    end
    d.chg = 0;
    if (surv.size() > 0) begin
      for (int k = 0; k < n; k++) begin
        r = isrow ? line : k;
        c = isrow ? k : line;
        if (!mk[r][c]) begin
          all1 = 1; all0 = 1;
          foreach (surv[j]) if (surv[j][k]) all0 = 0; else all1 = 0;
          if (all1 || all0) begin
            mk[r][c] = 1; ma[r][c] = all1; d.chg = 1;
          end
        end
      end
    end
    d.cnt = surv.size();
    d.e = 0;
`ifdef LINE_ERR_CHECK_EN
    d.e = (eff > 0 && surv.size() == 0);
`endif
    for (int rr = 0; rr < ROWS; rr++)
      for (int cc = 0; cc < COLS; cc++) begin
        d.kn[rr*COLS+cc] = mk[rr][cc];
        d.as[rr*COLS+cc] = ma[rr][cc];
      end
    d.cyc = 0;
  endtask

  task automatic wait_ready();
    int b = 0;
    while (!line_ready && b < 60) begin tick(); b++; end
    chk("line_ready_wait", line_ready, 1);
  endtask

  // gap_mode: 0 none, 1 one idle cycle between options, 2 random gaps; hold keeps line_valid high
  task automatic run_job(input int idx, input int cnt, input int gap_mode, input bit hold);
    done_t d;
    int eff, b;
    model_job(idx, cnt, d);
    wait_ready();
    line_idx = idx[IDX_W-1:0];
    line_cnt = cnt[CNT_W-1:0];
    line_valid = 1;
    tick();
    if (!hold) line_valid = 0;
    eff = (idx < ROWS + COLS) ? cnt : 0;
    if (eff == 0) begin d.cyc = cyc; done_q.push_back(d); end
    for (int i = 0; i < eff; i++) begin
      if (i > 0 && (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 2) == 0))) begin
        opt_valid = 0;
        tick();
      end
      opt_valid = 1;
      opt_data = job_opts[i];
      b = 0;
      while (!opt_ready && b < 20) begin tick(); b++; end
      chk("opt_ready", opt_ready, 1);
      if (hold) chk("line_ready_in_scan", line_ready, 0);
      tick();
      keep_q.push_back('{k: job_keeps[i], cyc: cyc});
    end
    opt_valid = 0;
    line_valid = 0;
    if (eff > 0) begin d.cyc = cyc + 1; done_q.push_back(d); end
    wait_ready();
  endtask

  task automatic clear_board();
    wait_ready();
    board_clr = 1;
    line_valid = 1;
    line_idx = '0;
    line_cnt = 7'd1;
    tick();
    board_clr = 0;
    line_valid = 0;
    foreach (mk[r, c]) begin mk[r][c] = 0; ma[r][c] = 0; end
    chk("clr_line_ready", line_ready, 1);
    chk("clr_opt_ready", opt_ready, 0);
    chk("clr_known", known, 0);
    chk("clr_assigned", assigned, 0);
  endtask

  always @(negedge clk) begin
    keep_t ke;
    done_t de;
    if (!rst) begin
      if (opt_keep_valid) begin
        if (keep_q.size() == 0) chk("keep_unexpected", opt_keep_valid, 0);
        else begin
          ke = keep_q.pop_front();
          chk("opt_keep", opt_keep, ke.k);
          chk("keep_cycle", cyc, ke.cyc);
        end
      end
      if (done) begin
        if (done_q.size() == 0) chk("done_unexpected", done, 0);
        else begin
          de = done_q.pop_front();
          chk("new_cnt", new_cnt, de.cnt);
          chk("changed", changed, de.chg);
          chk("err", err, de.e);
          chk("known", known, de.kn);
          chk("assigned", assigned, de.as);
          chk("done_cycle", cyc, de.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    foreach (mk[r, c]) begin mk[r][c] = 0; ma[r][c] = 0; sol[r][c] = 1'($urandom_range(0, 1)); end
    repeat (3) tick();
    rst = 0;
    chk("rst_known", known, 0);
    chk("rst_assigned", assigned, 0);
    chk("rst_done", done, 0);
    chk("rst_line_ready", line_ready, 1);
    chk("rst_opt_ready", opt_ready, 0);
    chk("rst_keep_valid", opt_keep_valid, 0);
    chk("rst_err", err, 0);

    job_opts = '{3'b101};
    run_job(0, 1, 0, 0);
    chk("t_row0_known", known, 9'b000000111);
    chk("t_row0_assigned", assigned, 9'b000000101);

    job_opts = '{3'b000, 3'b011};
    run_job(3, 2, 0, 0);
    chk("t_col0_known", known, 9'b001001111);
    chk("t_col0_assigned", assigned, 9'b000001101);

    job_opts = '{3'b000, 3'b111};
    run_job(0, 2, 0, 0);
    chk("t_unsolv_known", known, 9'b001001111);

    clear_board();
    job_opts = '{3'b110, 3'b011, 3'b010};
    run_job(1, 3, 0, 0);
    chk("t_row1_known", known, 9'b000010000);
    chk("t_row1_assigned", assigned, 9'b000010000);

    clear_board();
    job_opts = '{3'b110, 3'b011, 3'b010};
    run_job(1, 3, 1, 1);
    chk("t_bp_known", known, 9'b000010000);
    chk("t_bp_assigned", assigned, 9'b000010000);

    job_opts.delete();
    run_job(2, 0, 0, 0);
    job_opts = '{3'b111};
    run_job(6, 1, 0, 0);

    for (int j = 0; j < 60; j++) begin
      int idx, cnt;
      bit isrow;
      logic [LMAX-1:0] o;
      if (j % 12 == 11) clear_board();
      idx = $urandom_range(0, 7);
      cnt = $urandom_range(0, 6);
      isrow = idx < ROWS;
      job_opts.delete();
      for (int i = 0; i < cnt; i++) begin
        if ($urandom_range(0, 2) == 0 || idx >= ROWS + COLS) o = 3'($urandom_range(0, 7));
        else
          for (int k = 0; k < LMAX; k++)
            o[k] = isrow ? sol[idx][k] : sol[k][idx-ROWS];
        job_opts.push_back(o);
      end
      run_job(idx, cnt, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    repeat (5) tick();
    chk("keep_q_drained", keep_q.size(), 0);
    chk("done_q_drained", done_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
